// File: rtl/mul_hilo_ctrl.sv
// rtl/mul_hilo_ctrl.sv - sequencer and HI/LO holding stage for the shift-add multiplier
// Optional MTHI/MTLO register writes are enabled by defining MUL_HILO_MTHILO_EN.
module mul_hilo_ctrl #(
  parameter int WIDTH  = 32,
  parameter int CYCLES = 32,
  parameter int CNT_W  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [2*WIDTH-1:0] product,
  output logic [5:0]         mul_signal,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   dataOut
);

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] SIG_MUL = 6'b011001;
  localparam logic [5:0] SIG_OUT = 6'b111111;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  counter;
  logic              accept, do_mult, wr_hi, wr_lo;

  // Requests only count in IDLE; anything arriving while busy is dropped.
  assign accept  = start && (state == IDLE);
  assign do_mult = accept && (funct == F_MULTU);

`ifdef MUL_HILO_MTHILO_EN
  assign wr_hi = accept && (funct == F_MTHI);
  assign wr_lo = accept && (funct == F_MTLO);
`else
  logic unused_wdata;
  assign unused_wdata = ^{wdata, F_MTHI, F_MTLO};
  assign wr_hi = 1'b0;
  assign wr_lo = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    mul_signal = SIG_OUT;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (do_mult) state_nxt = RUN;
      RUN: begin
        mul_signal = SIG_MUL;
        if (counter == LAST) state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state <= state_nxt;
      if (do_mult)
        counter <= '0;
      else if (state == RUN)
        counter <= counter + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      dataOut <= '0;
    end else begin
      done <= (state == CAPTURE);
      if (state == CAPTURE) begin
        hi <= product[2*WIDTH-1:WIDTH];
        lo <= product[WIDTH-1:0];
      end else begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end
      if (accept && (funct == F_MFHI)) dataOut <= hi;
      if (accept && (funct == F_MFLO)) dataOut <= lo;
    end
  end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// tb/tb_mul_hilo_ctrl.sv - self-checking bench for mul_hilo_ctrl with a behavioural multiplier model
module tb_mul_hilo_ctrl;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] SIG_MUL = 6'b011001;
  localparam logic [5:0] SIG_OUT = 6'b111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] wdata = 32'd0;
  logic [63:0] product;
  logic [5:0]  mul_signal;
  logic        busy, done;
  logic [31:0] hi, lo, dataOut;

  logic [31:0] op_a = 32'd0, op_b = 32'd0;
  logic        clr_steps = 1'b0;
  int          steps = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_dout = 32'd0;

  always #5 clk = ~clk;

  mul_hilo_ctrl dut (
    .clk(clk), .reset(rst_n), .start(start), .funct(funct), .wdata(wdata),
    .product(product), .mul_signal(mul_signal), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .dataOut(dataOut)
  );

  // Multiplier stand-in: the true product appears only after exactly 32 MUL steps.
  always @(posedge clk) begin
    if (clr_steps) steps <= 0;
    else if (mul_signal == SIG_MUL) steps <= steps + 1;
  end
  assign product = (steps == 32) ? ({32'd0, op_a} * {32'd0, op_b})
                                 : (64'hA5A5_5A5A_0000_0000 | 64'(steps));

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic read_reg(input logic [5:0] f, input string name);
    @(negedge clk); start = 1'b1; funct = f;
    @(negedge clk); start = 1'b0;
    m_dout = (f == F_MFHI) ? m_hi : m_lo;
    check(name, 64'(dataOut), 64'(m_dout));
  endtask

  // inject: pulse a MULTU and an MFLO while busy; mflo_done: issue MFLO in the done cycle
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input bit inject, input bit mflo_done);
    int cyc, muls, busies;
    bit seen;
    logic [63:0] exp;
    exp = {32'd0, a} * {32'd0, b};
    @(negedge clk); op_a = a; op_b = b; start = 1'b1; funct = F_MULTU; clr_steps = 1'b1;
    @(negedge clk); start = 1'b0; clr_steps = 1'b0;
    cyc = 1; muls = 0; busies = 0; seen = 0;
    while (!seen && cyc < 100) begin
      if (mul_signal == SIG_MUL) muls++;
      if (busy) busies++;
      if (!done) begin
        start = inject && (cyc == 5 || cyc == 20);
        funct = (cyc == 5) ? F_MULTU : F_MFLO;
        if (cyc > 1) check("hilo_held", {hi, lo}, {m_hi, m_lo});
        @(negedge clk); cyc++;
      end else seen = 1;
    end
    start = 1'b0;
    check("latency", 64'(cyc), 64'd34);
    check("mul_count", 64'(muls), 64'd32);
    check("busy_count", 64'(busies), 64'd33);
    check("busy_at_done", 64'(busy), 64'd0);
    check("product", {hi, lo}, exp);
    check("dout_unchanged", 64'(dataOut), 64'(m_dout));
    m_hi = exp[63:32]; m_lo = exp[31:0];
    if (mflo_done) begin start = 1'b1; funct = F_MFLO; end
    @(negedge clk); start = 1'b0;
    check("done_pulse", 64'(done), 64'd0);
    check("signal_out", 64'(mul_signal), 64'(SIG_OUT));
    if (mflo_done) begin
      m_dout = m_lo;
      check("mflo_in_done", 64'(dataOut), 64'(m_dout));
    end
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic [31:0] exp_hi, exp_lo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{32'd7,          32'd6,          32'h0000_0000, 32'h0000_002A};
    vecs[3] = '{32'd0,          32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[5] = '{32'h8000_0000, 32'd2,          32'h0000_0001, 32'h0000_0000};

    #12;
    check("rst_signal", 64'(mul_signal), 64'(SIG_OUT));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_dout", 64'(dataOut), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_mult(vecs[i].a, vecs[i].b, 0, 0);
      check("vec_hi", 64'(hi), 64'(vecs[i].exp_hi));
      check("vec_lo", 64'(lo), 64'(vecs[i].exp_lo));
      read_reg(F_MFHI, "vec_mfhi");
      read_reg(F_MFLO, "vec_mflo");
    end

    for (int i = 0; i < 6; i++) begin
      run_mult($urandom, $urandom, 0, 0);
      read_reg((i % 2 == 0) ? F_MFHI : F_MFLO, "rand_read");
    end

    run_mult(32'h0BAD_F00D, 32'h1357_9BDF, 1, 0);
    read_reg(F_MFLO, "after_inject");

    run_mult(32'd7, 32'd6, 0, 1);

    // Reset in the middle of a run
    @(negedge clk); op_a = 32'd9; op_b = 32'd9; start = 1'b1; funct = F_MULTU; clr_steps = 1'b1;
    @(negedge clk); start = 1'b0; clr_steps = 1'b0;
    repeat (10) @(negedge clk);
    check("midrun_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_signal", 64'(mul_signal), 64'(SIG_OUT));
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_dout", 64'(dataOut), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0; m_dout = 32'd0;
    @(negedge clk); rst_n = 1'b1;
    begin
      int dones, busies;
      dones = 0; busies = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) dones++;
        if (busy) busies++;
      end
      check("midrst_no_done", 64'(dones), 64'd0);
      check("midrst_idle", 64'(busies), 64'd0);
    end

    // MTHI: loads only when the optional feature is built in
    @(negedge clk); start = 1'b1; funct = F_MTHI; wdata = 32'h1234_5678;
    @(negedge clk); start = 1'b0;
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_signal", 64'(mul_signal), 64'(SIG_OUT));
`ifdef MUL_HILO_MTHILO_EN
    m_hi = 32'h1234_5678;
`endif
    check("mthi_hi", 64'(hi), 64'(m_hi));
    read_reg(F_MFHI, "mthi_mfhi");
    check("mthi_lo", 64'(lo), 64'(m_lo));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
